// File: rtl/audio_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_filter_pkg
// Description : Shared types and helpers for the stereo moving-average filter:
//               sequencer state encoding and running-sum width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_filter_pkg;

  // Sequencer states: wait for both codec sides, pop, update history, push.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    UPD  = 2'd2,
    WR   = 2'd3
  } state_e;

  // A sum of 2^log2_depth samples needs log2_depth extra bits to never overflow.
  function automatic int sum_width(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/avg_channel.sv
`default_nettype none
// ============================================================================
// Module      : avg_channel
// Description : One channel of the moving-average filter. Keeps a circular
//               history of 2^LOG2_DEPTH samples and a running sum. On an update
//               strobe the oldest sample is replaced by the new one. The mean
//               that the sum will hold after the update is offered
//               combinationally so the caller can register it on that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module avg_channel
  import audio_filter_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_upd,
  input  logic signed [DATA_W-1:0] i_in,
  output logic signed [DATA_W-1:0] o_mean_next
);

  localparam int SUM_W = sum_width(DATA_W, LOG2_DEPTH);
  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic signed [DATA_W-1:0]   hist_q [DEPTH];
  logic        [LOG2_DEPTH-1:0] ptr_q, ptr_d;
  logic signed [SUM_W-1:0]    sum_q, sum_d;
  logic signed [SUM_W-1:0]    in_ext, old_ext;

  // Next running sum: add the incoming sample, drop the one it overwrites.
  always_comb begin
    in_ext      = {{LOG2_DEPTH{i_in[DATA_W-1]}}, i_in};
    old_ext     = {{LOG2_DEPTH{hist_q[ptr_q][DATA_W-1]}}, hist_q[ptr_q]};
    sum_d       = sum_q + in_ext - old_ext;
    ptr_d       = ptr_q + LOG2_DEPTH'(1);
    // Dropping the low bits is an arithmetic shift; the result fits DATA_W.
    o_mean_next = sum_d[SUM_W-1:LOG2_DEPTH];
  end

  // History, pointer and sum advance together on every accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      sum_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else if (i_upd) begin
      hist_q[ptr_q] <= i_in;
      sum_q         <= sum_d;
      ptr_q         <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_avg_filter.sv
`default_nettype none
// ============================================================================
// Module      : audio_avg_filter
// Description : Stereo moving-average filter between codec read and write
//               sides. Pops one stereo sample, updates both channel histories,
//               then pushes either the window mean or the raw sample (bypass).
//               A sample is only popped when the write side can take it.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_avg_filter
  import audio_filter_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int LOG2_DEPTH = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              bypass,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right
);

  state_e                   state_q;
  logic                     read_q, write_q, mode_q;
  logic signed [DATA_W-1:0] in_l_q, in_r_q;
  logic        [DATA_W-1:0] wd_l_q, wd_r_q;
  logic signed [DATA_W-1:0] mean_next_l, mean_next_r;
  logic                     upd;

  // Both channels advance only in the update state.
  always_comb begin
    upd = (state_q == UPD);
  end

  avg_channel #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_avg_left (
    .clk         (CLOCK_50),
    .rst         (reset),
    .i_upd       (upd),
    .i_in        (in_l_q),
    .o_mean_next (mean_next_l)
  );

  avg_channel #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_avg_right (
    .clk         (CLOCK_50),
    .rst         (reset),
    .i_upd       (upd),
    .i_in        (in_r_q),
    .o_mean_next (mean_next_r)
  );

  // Sequencer with registered strobes; writedata is loaded on the same edge
  // that raises write, from the mode latched on that edge, and then held.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      mode_q  <= 1'b0;
      in_l_q  <= '0;
      in_r_q  <= '0;
      wd_l_q  <= '0;
      wd_r_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          write_q <= 1'b0;
          if (read_ready && write_ready) begin
            read_q  <= 1'b1;
            state_q <= RD;
          end
        end
        RD: begin
          read_q  <= 1'b0;
          in_l_q  <= readdata_left;
          in_r_q  <= readdata_right;
          state_q <= UPD;
        end
        UPD: begin
          mode_q  <= bypass;
          wd_l_q  <= bypass ? in_l_q : mean_next_l;
          wd_r_q  <= bypass ? in_r_q : mean_next_r;
          write_q <= 1'b1;
          state_q <= WR;
        end
        WR: begin
          write_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The latched mode only selects the output during the update edge; it is
  // kept as state so the active mode of the last output is observable.
  logic mode_unused;
  always_comb begin
    mode_unused = mode_q;
  end

  always_comb begin
    read            = read_q;
    write           = write_q;
    writedata_left  = wd_l_q;
    writedata_right = wd_r_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_avg_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_avg_filter
// Description : Self-checking bench for audio_avg_filter with a behavioural
//               sliding-window model and directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_avg_filter;

  localparam int DW    = 24;
  localparam int L2    = 3;
  localparam int DEPTH = 8;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          bypass = 1'b0;
  logic          read_ready = 1'b0;
  logic          write_ready = 1'b0;
  logic [DW-1:0] readdata_left = '0;
  logic [DW-1:0] readdata_right = '0;
  logic          read, write;
  logic [DW-1:0] writedata_left, writedata_right;

  audio_avg_filter #(.DATA_W(DW), .LOG2_DEPTH(L2)) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .bypass          (bypass),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .read            (read),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int hist_l[$], hist_r[$];
  int exp_l[$], exp_r[$];
  int log_l[$], log_r[$];
  int held_l = 0, held_r = 0;
  int cyc = 0, rd_cyc = 0;
  logic rst_at_edge = 1'b1;

  function automatic int floor_mean(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    if (s >= 0) return s / DEPTH;
    return -((-s + DEPTH - 1) / DEPTH);
  endfunction

  task automatic model_reset();
    hist_l.delete(); hist_r.delete();
    for (int i = 0; i < DEPTH; i++) begin
      hist_l.push_back(0);
      hist_r.push_back(0);
    end
    exp_l.delete(); exp_r.delete();
    held_l = 0; held_r = 0;
  endtask

  always @(posedge CLOCK_50) rst_at_edge <= reset;

  // Single compare process: outputs sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    if (rst_at_edge) begin
      model_reset();
      check("rst_strobes", int'({read, write}), 0);
      check("rst_wd_left", $signed(writedata_left), 0);
      check("rst_wd_right", $signed(writedata_right), 0);
    end else begin
      cyc++;
      check("rd_wr_overlap", int'(read & write), 0);
      if (read) begin
        int raw_l, raw_r;
        raw_l = $signed(readdata_left);
        raw_r = $signed(readdata_right);
        hist_l.push_back(raw_l); void'(hist_l.pop_front());
        hist_r.push_back(raw_r); void'(hist_r.pop_front());
        exp_l.push_back(bypass ? raw_l : floor_mean(hist_l));
        exp_r.push_back(bypass ? raw_r : floor_mean(hist_r));
        rd_cyc = cyc;
      end
      if (write) begin
        check("write_has_pending", int'(exp_l.size() > 0), 1);
        check("rd_to_wr_latency", cyc - rd_cyc, 2);
        if (exp_l.size() > 0) begin
          check("wd_left", $signed(writedata_left), exp_l.pop_front());
          check("wd_right", $signed(writedata_right), exp_r.pop_front());
        end
        held_l = $signed(writedata_left);
        held_r = $signed(writedata_right);
        log_l.push_back(held_l);
        log_r.push_back(held_r);
      end else begin
        check("wd_hold_left", $signed(writedata_left), held_l);
        check("wd_hold_right", $signed(writedata_right), held_r);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic send(input int l, input int r, input logic byp);
    readdata_left  = DW'(l);
    readdata_right = DW'(r);
    bypass         = byp;
    read_ready     = 1'b1;
    write_ready    = 1'b1;
    for (int t = 0; t < 40 && !read; t++) step();
    check("read_seen", int'(read), 1);
    read_ready = 1'b0;
    for (int t = 0; t < 40 && !write; t++) step();
    check("write_seen", int'(write), 1);
  endtask

  task automatic apply_reset(input int n);
    read_ready = 1'b0;
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    int busy;
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int busy;
    // Reset held 3 cycles with both ready lines high.
    readdata_left  = DW'(800);
    readdata_right = DW'(-800);
    read_ready  = 1'b1;
    write_ready = 1'b1;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("first_read_after_reset", int'(read), 1);
    read_ready = 1'b0;
    for (int t = 0; t < 40 && !write; t++) step();
    check("write_seen", int'(write), 1);
    for (int i = 1; i < 10; i++) send(800, -800, 1'b0);
    check("ramp_count", log_l.size(), 10);
    for (int i = 0; i < 10 && i < log_l.size(); i++) begin
      check("ramp_left", log_l[i], (i < 8) ? 100 * (i + 1) : 800);
      check("ramp_right", log_r[i], (i < 8) ? -100 * (i + 1) : -800);
    end

    // Impulse of -1: floor(-1/8) = -1 for a full window, then 0.
    apply_reset(2);
    log_l.delete(); log_r.delete();
    send(-1, 0, 1'b0);
    for (int i = 1; i < 10; i++) send(0, 0, 1'b0);
    check("impulse_count", log_l.size(), 10);
    for (int i = 0; i < 10 && i < log_l.size(); i++) begin
      check("impulse_left", log_l[i], (i < 8) ? -1 : 0);
      check("impulse_right", log_r[i], 0);
    end

    // Bypass passes raw samples; history still fills in the background.
    apply_reset(2);
    log_l.delete(); log_r.delete();
    send('h123456, -'h123456, 1'b1);
    for (int i = 0; i < 8; i++) send('h100, 'h100, 1'b1);
    send('h100, 'h100, 1'b0);
    check("bypass_count", log_l.size(), 10);
    check("bypass_left", log_l[0], 'h123456);
    check("bypass_right", log_r[0], -'h123456);
    check("bypass_const_left", log_l[5], 'h100);
    check("avg_after_bypass_left", log_l[9], 'h100);
    check("avg_after_bypass_right", log_r[9], 'h100);

    // Write side not ready: nothing is popped or pushed.
    read_ready  = 1'b1;
    write_ready = 1'b0;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      busy += int'(read | write);
    end
    check("stall_no_activity", busy, 0);
    write_ready = 1'b1;
    step();
    check("stall_read_at_1", int'(read), 1);
    read_ready = 1'b0;
    step();
    check("stall_gap", int'({read, write}), 0);
    step();
    check("stall_write_at_3", int'(write), 1);
    step();

    // Reset during the update cycle discards the popped sample.
    readdata_left  = DW'(2048);
    readdata_right = DW'(-2048);
    bypass      = 1'b0;
    read_ready  = 1'b1;
    write_ready = 1'b1;
    for (int t = 0; t < 40 && !read; t++) step();
    check("read_seen", int'(read), 1);
    read_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    busy = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      busy += int'(write);
    end
    check("no_write_after_upd_reset", busy, 0);
    log_l.delete(); log_r.delete();
    send(2048, -2048, 1'b0);
    check("post_reset_left", log_l[0], 256);
    check("post_reset_right", log_r[0], -256);

    repeat (4) step();
    check("no_pending_samples", exp_l.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_avg_filter.md
# audio_avg_filter

Parametrised stereo moving-average filter sitting between the audio codec's read and write sides, in place of the sample pass-through. Each accepted stereo sample is pushed into a per-channel circular history of 2^LOG2_DEPTH samples; the block writes back the arithmetic mean of that history, or the raw sample when bypass is selected. Width and depth are generic; mode can be switched at run time without glitches.

## Interface
- DATA_W, 24, sample width (signed two's complement), matches codec data ports
- LOG2_DEPTH, 3, log2 of averaging window; DEPTH = 2^LOG2_DEPTH, legal 1..6
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- bypass  in  1  1 = output raw sample, 0 = output window mean; sampled per sample
- read_ready  in  1  codec has a stereo sample available
- write_ready  in  1  codec can accept a stereo sample
- readdata_left, readdata_right  in  DATA_W  incoming samples, valid while read_ready
- read  out  1  one-cycle pop strobe to codec
- write  out  1  one-cycle push strobe to codec
- writedata_left, writedata_right  out  DATA_W  outgoing samples, valid while write=1

## Operation
- FSM states: IDLE, RD, UPD, WR.
- IDLE: if read_ready & write_ready -> RD; else stay. Both must be high, so no sample is popped that cannot be written.
- RD: read=1; capture readdata_left/right into in_l/in_r; -> UPD.
- UPD: per channel sum <= sum + in - hist[ptr]; hist[ptr] <= in; ptr <= ptr+1 (wraps at DEPTH-1 -> 0); latch bypass into mode_q; -> WR.
- WR: write=1; writedata = mode_q ? in : (sum >>> LOG2_DEPTH); -> IDLE.
- History is always updated, including in bypass, so returning to averaging produces the correct mean immediately.
- Arithmetic: sum is SUM_W = DATA_W+LOG2_DEPTH bits, signed, sign-extended inputs; never overflows. Mean is arithmetic right shift (rounds toward -inf), result fits DATA_W exactly.
- Warm-up: history and sums reset to 0; first DEPTH outputs ramp (zeros count in the mean).
- Reset at any state: FSM -> IDLE, read=0, write=0, writedata=0, ptr=0, sums=0, history=0, mode_q=0. A sample popped but not yet written when reset asserts is discarded.
- bypass changes mid-sample take effect at the next UPD.

## Timing
- Reset values: read=0, write=0, writedata_left=writedata_right=0.
- read_ready & write_ready high at edge k -> read high in cycle k+1 only -> write high in cycle k+3 only -> IDLE in k+4.
- read and write are registered, never high together, each exactly one cycle per sample.
- Throughput: one stereo sample per 4 cycles minimum (far above 48 kHz at 50 MHz).
- writedata registered, held stable from WR until the next WR or reset.
- write_ready dropping after the IDLE check is ignored (codec FIFO guaranteed one slot by the check).

## Structure
- Package audio_filter_pkg: state encoding constants (IDLE, RD, UPD, WR), SUM_W derivation function.
- Sub-module avg_channel (instantiated twice, left/right): history register array, pointer, running sum, mean output; inputs in, update strobe, reset. Top holds FSM, capture registers, mode_q, output mux.
- Pointer may be shared, but each avg_channel keeps its own for independence.

## Test plan
- Reset held 3 cycles with read_ready=write_ready=1 -> read=write=0, writedata=0 throughout; first read 1 cycle after reset release.
- DATA_W=24, LOG2_DEPTH=3, left=800, right=-800 for 10 samples -> left outputs 100,200,...,800,800,800; right -100,...,-800,-800,-800.
- Impulse: left=-1 once then zeros -> outputs -1 for 8 samples (floor of -1/8), then 0.
- bypass=1, input 0x123456/0xEDCBAA -> identical output; switch bypass=0 after 8 constant samples of 0x000100 -> first averaged output 0x000100.
- write_ready=0 with read_ready=1 for 20 cycles -> no read, no write; raise write_ready -> read at +1, write at +3.
- Assert reset during UPD -> no write issued, next output after release equals in>>>3 (history cleared).
